hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Pipeline hazard controller for the PPU: tracks destination registers of in-flight EX/MEM/WB
//  instructions and drives operand forwarding muxes for the ID stage.
//  Also generates load-use stalls (PC/IF-ID hold plus ID/EX NOP insertion) and the IF/ID flush
//  on a taken branch reported by the condition handler. Sits beside control_unit and drives the
//  PC, IF/ID and ID/EX register enables and the control-word NOP mux.
// PARAMETERS
//  RA_W    4   register address width (R0..R15)
//  PC_REG  15  register index never forwarded (PC reads come from the fetch path)
//  CNT_W   16  perf counter width (used only with HAZ_PERF_CNT_EN)
// PORTS
//  clk           in   1     pipeline clock, rising edge
//  reset         in   1     asynchronous, active-high; clears all state
//  id_valid      in   1     ID holds a real instruction (0 = bubble)
//  id_rn,id_rm   in   RA_W  ID source operands A,B
//  id_rd         in   RA_W  ID destination; also store-data source C
//  id_use_rn/rm  in   1     operand A/B is read
//  id_use_rd     in   1     rd is read as store data (STR)
//  id_rf_en      in   1     ID instruction writes rd (C_U_out[0])
//  id_load       in   1     ID instruction is a load (C_U_out[1])
//  branch_taken  in   1     choose_ta_r_nop from condition handler (ID stage)
//  pc_ld         out  1     PC load enable
//  ifid_ld       out  1     IF/ID load enable
//  ifid_flush    out  1     IF/ID clear to NOP next edge
//  idex_nop      out  1     select NOP control word into ID/EX
//  fwd_a,fwd_b,fwd_c out 2  operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//  stall_cnt,flush_cnt out CNT_W  perf counters (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//  - Scoreboard: three stages {valid,rd,rf_en,load} for EX, MEM, WB. Each clk edge EX<=ID-entry,
//    MEM<=EX, WB<=MEM. ID-entry is a bubble (valid=0) when idex_nop=1 or id_valid=0.
//  - Reset: all valid bits 0; state RUN; pc_ld=1, ifid_ld=1, ifid_flush=0, idex_nop=0, fwd_*=00,
//    counters 0. Reset mid-stall returns to RUN and drops in-flight entries.
//  - Match(src,stage) = use & stage.valid & stage.rf_en & (src==stage.rd) & (src!=PC_REG).
//  - Forward priority EX > MEM > WB (youngest wins); no match -> 00. Combinational from ID ports.
//  - Load-use: Match against EX with EX.load=1 -> hazard. EX is never chosen as a load source;
//    MEM/WB may be.
//  - FSM: RUN: hazard -> pc_ld=0, ifid_ld=0, idex_nop=1 (same cycle), go STALL.
//    STALL: load now in MEM; forward via 10; outputs normal, go RUN. A second dependent load
//    re-enters STALL the next cycle.
//  - Branch: branch_taken & ~stall -> ifid_flush=1 for one cycle; pc_ld stays 1 (target load).
//    Stall has priority: branch_taken is ignored while pc_ld=0 and is re-evaluated after.
//  - Simultaneous hazard on A and C: one stall covers both. Bubbles (id_valid=0) never stall.
//  - Latency: all outputs combinational from inputs plus registered scoreboard; zero-cycle response.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt increments each cycle idex_nop=1, flush_cnt each cycle
//    ifid_flush=1; both saturate at all-ones and clear on reset.
//  Undefined: counter ports present and tied to 0; no counter flops.
// STRUCTURE
//  - ppu_pkg: FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants, hz_state_t {RUN,STALL}, RA_W default.
//  - Sub-module hazard_scoreboard: the three-stage entry shift register with match outputs.
//    Top holds the FSM, priority encoders and counters.
// TESTING
//  1 ADD R1 then ADD R2,R1,R3 -> fwd_a=01, no stall; next cycle with R1 only in MEM -> fwd_a=10.
//  2 LDR R4 then ADD R5,R4,R4 -> cycle0 pc_ld=0, ifid_ld=0, idex_nop=1;
//    cycle1 fwd_a=fwd_b=10, pc_ld=1.
//  3 R6 written in EX and WB, ID reads R6 -> fwd=01 (EX wins).
//  4 branch_taken=1 with no hazard -> ifid_flush=1 one cycle; same cycle as load-use ->
//    flush=0, stall, and flush=1 after the stall.
//  5 ID reads R15 while EX writes R15 -> fwd=00; STR R7 after ADD R7 -> fwd_c=01.
//  6 reset asserted during STALL -> outputs to reset values immediately; with HAZ_PERF_CNT_EN,
//    2^CNT_W+3 stalls -> stall_cnt=all ones.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants, FSM state type and forward-select helper for the PPU hazard logic
package ppu_pkg;

    localparam int RA_W_DEF   = 4;
    localparam int PC_REG_DEF = 15;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {RUN, STALL} hz_state_t;

    // youngest producer wins; a load still in EX has no data yet, so it is skipped
    function automatic logic [1:0] fwd_sel(input logic [2:0] hit, input logic ex_load);
        return (hit[0] && !ex_load) ? FWD_EX : hit[1] ? FWD_MEM : hit[2] ? FWD_WB : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination tracker with per-operand match vectors (bit0 EX, bit1 MEM, bit2 WB)
module hazard_scoreboard
    import ppu_pkg::*;
#(
    parameter int RA_W   = RA_W_DEF,
    parameter int PC_REG = PC_REG_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ent_valid,
    input  logic [RA_W-1:0] ent_rd,
    input  logic            ent_rf_en,
    input  logic            ent_load,
    input  logic [RA_W-1:0] src_a,
    input  logic [RA_W-1:0] src_b,
    input  logic [RA_W-1:0] src_c,
    input  logic            use_a,
    input  logic            use_b,
    input  logic            use_c,
    output logic [2:0]      hit_a,
    output logic [2:0]      hit_b,
    output logic [2:0]      hit_c,
    output logic            ex_load
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            rf_en;
        logic            load;
    } entry_t;

    entry_t       ent;
    entry_t [2:0] stg;

    assign ent     = '{valid: ent_valid, rd: ent_rd, rf_en: ent_rf_en, load: ent_load};
    assign ex_load = stg[0].load;

    // PC reads come from the fetch path, so the PC register never matches
    function automatic logic hit(input logic en, input logic [RA_W-1:0] src, input entry_t e);
        return en && e.valid && e.rf_en && (src == e.rd) && (src != RA_W'(PC_REG));
    endfunction

    // advance the in-flight entries one stage per clock: ID -> EX -> MEM -> WB
    always_ff @(posedge clk or posedge reset)
        if (reset) stg <= '0;
        else       stg <= {stg[1:0], ent};

    // per-stage match of each source operand
    always_comb
        for (int i = 0; i < 3; i++) begin
            hit_a[i] = hit(use_a, src_a, stg[i]);
            hit_b[i] = hit(use_b, src_b, stg[i]);
            hit_c[i] = hit(use_c, src_c, stg[i]);
        end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding select, load-use stall and branch flush control; HAZ_PERF_CNT_EN adds perf counters
module hazard_fwd_ctrl
    import ppu_pkg::*;
#(
    parameter int RA_W   = RA_W_DEF,
    parameter int PC_REG = PC_REG_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rn,
    input  logic [RA_W-1:0]  id_rm,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_rf_en,
    input  logic             id_load,
    input  logic             branch_taken,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             ifid_flush,
    output logic             idex_nop,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t  state, state_nxt;
    logic [2:0] hit_a, hit_b, hit_c;
    logic       ex_load, hazard, stall;

    hazard_scoreboard #(.RA_W(RA_W), .PC_REG(PC_REG)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .ent_valid (id_valid & ~idex_nop),
        .ent_rd    (id_rd),
        .ent_rf_en (id_rf_en),
        .ent_load  (id_load),
        .src_a     (id_rn),
        .src_b     (id_rm),
        .src_c     (id_rd),
        .use_a     (id_use_rn),
        .use_b     (id_use_rm),
        .use_c     (id_use_rd),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .hit_c     (hit_c),
        .ex_load   (ex_load)
    );

    // any read operand depending on a load still in EX; bubbles never stall
    assign hazard = id_valid & ex_load & (hit_a[0] | hit_b[0] | hit_c[0]);

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= RUN;
        else       state <= state_nxt;

    // one stall cycle per load-use, after which the load data sits in MEM
    always_comb
        state_nxt = (state == RUN && hazard) ? STALL : RUN;

    // pipeline enables, NOP insert, flush and forward selects; stall masks the branch flush
    always_comb begin
        stall      = ~reset & (state == RUN) & hazard;
        pc_ld      = ~stall;
        ifid_ld    = ~stall;
        idex_nop   = stall;
        ifid_flush = ~reset & branch_taken & ~stall;
        fwd_a      = fwd_sel(hit_a, ex_load);
        fwd_b      = fwd_sel(hit_b, ex_load);
        fwd_c      = fwd_sel(hit_c, ex_load);
    end

`ifdef HAZ_PERF_CNT_EN
    // saturating stall and flush cycle counters
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_nop && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
